// File: rtl/v_pkg.sv
// Shared types for the vector coprocessor result writeback path.
// A job is one completed lane operation waiting to be written to the VRF.
package v_pkg;

  localparam int WB_VLEN = 128;
  localparam int WB_NREG = 32;
  localparam int WB_AW   = $clog2(WB_NREG);

  typedef enum logic {
    IDLE,
    WRITE
  } wb_state_e;

  typedef struct packed {
    logic                       src;
    logic [3:0][WB_VLEN-1:0]    data;
    logic [WB_AW-1:0]           vd;
    logic [2:0]                 nbeats;
  } wb_job_t;

  // Reserved group encodings collapse to a single register.
  function automatic logic [2:0] lmul_to_nbeats(input logic [2:0] lmul);
    case (lmul)
      3'd1:    return 3'd2;
      3'd2:    return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/v_wb_slot.sv
// One writeback job register; used for both the active and the pending job.
// Load wins over clear so a slot can be refilled in the cycle it empties.
module v_wb_slot
  import v_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  logic    clear,
  input  wb_job_t job_in,
  output wb_job_t job,
  output logic    valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      job   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      job   <= job_in;
      valid <= 1'b1;
    end else if (clear) begin
      job   <= '0;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/v_wb_sequencer.sv
// Writes completed ALU/MUL register groups into the VRF, one register per beat,
// with an active job plus a one-deep pending job absorbing a second completion.
module v_wb_sequencer
  import v_pkg::*;
#(
  parameter int VLEN = WB_VLEN,
  parameter int NREG = WB_NREG
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    done_valu,
  input  logic                    done_vmul,
  input  logic [VLEN-1:0]         result_valu_1,
  input  logic [VLEN-1:0]         result_valu_2,
  input  logic [VLEN-1:0]         result_valu_3,
  input  logic [VLEN-1:0]         result_valu_4,
  input  logic [VLEN-1:0]         result_vmul_1,
  input  logic [VLEN-1:0]         result_vmul_2,
  input  logic [VLEN-1:0]         result_vmul_3,
  input  logic [VLEN-1:0]         result_vmul_4,
  input  logic [$clog2(NREG)-1:0] vd,
  input  logic [2:0]              lmul,
  output logic                    vrf_we,
  output logic [$clog2(NREG)-1:0] vrf_waddr,
  output logic [VLEN-1:0]         vrf_wdata,
  input  logic                    vrf_wready,
  output logic                    wb_busy,
  output logic                    wb_done,
  output logic                    wb_src,
  output logic                    wb_overflow
);

  wb_state_e  state;
  logic [1:0] idx;
  logic       done_valu_q;
  logic       done_vmul_q;

  wb_job_t act_job, pend_job, act_in, pend_in, alu_job, mul_job;
  logic    act_valid, pend_valid;
  logic    act_load, act_clear, pend_load, pend_clear;
  logic    ev_alu, ev_mul, accept, last, both_open, overflow_set;

  v_wb_slot u_active (
    .clk    (clk),
    .rst    (rst),
    .load   (act_load),
    .clear  (act_clear),
    .job_in (act_in),
    .job    (act_job),
    .valid  (act_valid)
  );

  v_wb_slot u_pending (
    .clk    (clk),
    .rst    (rst),
    .load   (pend_load),
    .clear  (pend_clear),
    .job_in (pend_in),
    .job    (pend_job),
    .valid  (pend_valid)
  );

  assign ev_alu = done_valu && !done_valu_q;
  assign ev_mul = done_vmul && !done_vmul_q;
  assign accept = vrf_we && vrf_wready;
  assign last   = accept && ({1'b0, idx} == act_job.nbeats - 3'd1);

  // A final accept with nothing pending frees both slots, exactly like IDLE.
  assign both_open = (state == IDLE) || (last && !pend_valid);

  always_comb begin
    alu_job.src    = 1'b0;
    alu_job.data   = {result_valu_4, result_valu_3, result_valu_2, result_valu_1};
    alu_job.vd     = vd;
    alu_job.nbeats = lmul_to_nbeats(lmul);
    mul_job.src    = 1'b1;
    mul_job.data   = {result_vmul_4, result_vmul_3, result_vmul_2, result_vmul_1};
    mul_job.vd     = vd;
    mul_job.nbeats = lmul_to_nbeats(lmul);
  end

  always_comb begin
    act_load     = 1'b0;
    act_clear    = 1'b0;
    act_in       = pend_job;
    pend_load    = 1'b0;
    pend_clear   = 1'b0;
    pend_in      = alu_job;
    overflow_set = 1'b0;
    if (both_open) begin
      if (ev_alu) begin
        act_load = 1'b1;
        act_in   = alu_job;
        if (ev_mul) begin
          pend_load = 1'b1;
          pend_in   = mul_job;
        end
      end else if (ev_mul) begin
        act_load = 1'b1;
        act_in   = mul_job;
      end else if (last) begin
        act_clear = 1'b1;
      end
    end else begin
      if (last) begin
        act_load = 1'b1;
      end
      // Promotion empties the pending slot in the same edge a new event lands.
      if (ev_alu || ev_mul) begin
        if (!pend_valid || last) begin
          pend_load    = 1'b1;
          pend_in      = ev_alu ? alu_job : mul_job;
          overflow_set = ev_alu && ev_mul;
        end else begin
          overflow_set = 1'b1;
        end
      end
      if (last && !pend_load) begin
        pend_clear = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 2'd0;
      done_valu_q <= 1'b0;
      done_vmul_q <= 1'b0;
      wb_done     <= 1'b0;
      wb_src      <= 1'b0;
      wb_overflow <= 1'b0;
    end else begin
      done_valu_q <= done_valu;
      done_vmul_q <= done_vmul;
      wb_done     <= last;
      if (last) begin
        wb_src <= act_job.src;
      end
      if (overflow_set) begin
        wb_overflow <= 1'b1;
      end
      case (state)
        IDLE: begin
          idx <= 2'd0;
          if (ev_alu || ev_mul) begin
            state <= WRITE;
          end
        end
        WRITE: begin
          if (last) begin
            idx <= 2'd0;
            if (!pend_valid && !ev_alu && !ev_mul) begin
              state <= IDLE;
            end
          end else if (accept) begin
            idx <= idx + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign vrf_we    = (state == WRITE);
  assign vrf_waddr = act_job.vd + WB_AW'(idx);
  assign vrf_wdata = act_job.data[idx];
  assign wb_busy   = (state == WRITE) || pend_valid;

endmodule

// File: doc/v_wb_sequencer.md
# v_wb_sequencer

Result writeback sequencer for the vector coprocessor. Sits downstream of the ALU/MUL lane array. It detects completion of a lane operation, captures the 1–4 result registers of the register group, and writes them one 128-bit register per beat into the vector register file (VRF) write port, starting at `vd`, with a valid/ready handshake. A one-deep pending slot absorbs a second completion, including simultaneous ALU and MUL completions.

## Interface
Parameters:
- `VLEN`, 128: bits per vector register and per write beat.
- `NREG`, 32: VRF depth; address width is `$clog2(NREG)` = 5.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `done_valu` in 1: ALU lane completion level; a rising edge starts a writeback.
- `done_vmul` in 1: MUL lane completion level; a rising edge starts a writeback.
- `result_valu_1..4` in VLEN each: ALU group results, register index 0..3.
- `result_vmul_1..4` in VLEN each: MUL group results, register index 0..3.
- `vd` in 5: destination base register, sampled at capture.
- `lmul` in 3: group size, sampled at capture. 0 = 1 register, 1 = 2, 2 = 4; 3..7 are reserved and treated as 1.
- `vrf_we` out 1: write valid.
- `vrf_waddr` out 5: write address.
- `vrf_wdata` out VLEN: write data.
- `vrf_wready` in 1: VRF accepts the beat when `vrf_we && vrf_wready`.
- `wb_busy` out 1: an active or pending job exists.
- `wb_done` out 1: one-cycle pulse after the last beat of a job is accepted.
- `wb_src` out 1: source of the job reported by `wb_done`; 0 = ALU, 1 = MUL.
- `wb_overflow` out 1: sticky; a completion arrived with both the active and pending slots full.

## Operation
- Edge detect: registered copies `done_valu_q` and `done_vmul_q`. An event fires when `done_x && !done_x_q`.
- Capture of a job records source, all four results, `vd`, and `nbeats` (1, 2 or 4), all taken from the values present in the event cycle.
- FSM states:
  - IDLE: on an event, load the active slot and go to WRITE.
  - WRITE: present beat `idx`. On accept, `idx++`. On accept of the last beat (`idx == nbeats-1`):
    - if pending is valid, move pending into active, reset `idx` to 0, and stay in WRITE (back-to-back, no bubble);
    - otherwise go to IDLE.
- Beat `k`: `vrf_waddr = vd + k`, modulo 32 (wraps). `vrf_wdata` = result `k+1` of the job's source.
- Events while in WRITE go to pending if pending is empty. An event that arrives in the same edge as pending→active promotion is written into pending.
- Simultaneous ALU and MUL events: ALU is taken first.
  - In IDLE, ALU goes to active and MUL to pending.
  - In WRITE with pending empty, ALU goes to pending and MUL sets `wb_overflow` and is dropped.
- Any event with no free slot sets `wb_overflow`; the event is dropped and the active job is unaffected.
- `vrf_we` = (state == WRITE). Address and data hold stable while `vrf_we && !vrf_wready`.

## Timing
- Reset values: `vrf_we` 0, `vrf_waddr` 0, `vrf_wdata` 0, `wb_busy` 0, `wb_done` 0, `wb_src` 0, `wb_overflow` 0. Also FSM = IDLE, pending invalid, `done_*_q` = 0.
- An event sampled at edge N gives the first `vrf_we` in cycle N+1.
- With `vrf_wready` held high, a job takes exactly `nbeats` cycles. Each low cycle of `vrf_wready` adds one cycle.
- `wb_done` and `wb_src` are registered: they pulse in the cycle after the final accept.
- `wb_busy` is high from cycle N+1 until the cycle after the final accept of the last job.
- Reset asserted mid-job aborts the job immediately: no further beats, pending is discarded, and no `wb_done` pulse is issued.
- A `done_*` level held high across many cycles produces exactly one event.

## Structure
- Shared package `v_pkg`:
  - `wb_job_t` struct: src, `data[4]`, vd, nbeats;
  - `wb_state_e` enum: IDLE, WRITE;
  - function `lmul_to_nbeats`.
- One sub-module: `v_wb_slot`, a job register with load, valid and clear. It is instantiated twice, for active and pending.
- FSM, edge detect and beat counter live in the top.

## Test plan
- ALU, 1 register: `lmul=0`, `vd=5`, `done_valu` rises with `vrf_wready=1`. Expect one beat next cycle: addr 5, data `result_valu_1`; then `wb_done=1`, `wb_src=0`.
- MUL, 4 registers with backpressure: `lmul=2`, `vd=8`, `vrf_wready` low for 2 cycles at beat 1. Expect addrs 8, 9, 10, 11 in order; beat 1 held stable while stalled; total 6 cycles.
- Wrap-around: `lmul=2`, `vd=30`. Expect addrs 30, 31, 0, 1.
- Simultaneous ALU and MUL events from IDLE, both `lmul=1`, with `vd=2` sampled for both. Expect ALU beats at 2, 3, then MUL beats at 2, 3 back-to-back. Expect two `wb_done` pulses, `wb_src` 0 then 1, and `wb_overflow=0`.
- Overflow: a third event while active and pending are both full. Expect `wb_overflow=1` (sticky), the dropped data never written, and the first two jobs written intact.
- Reset mid-job: assert `rst` during beat 2 of a 4-beat job. Expect `vrf_we=0` the next cycle, all outputs at reset values, and no `wb_done` pulse.
